// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the 2-bit branch history table.
// The counter MSB is the taken/not-taken prediction.
package branch_predict_unit_pkg;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_SNT  = 2'b00;
    localparam bht_cnt_t BHT_WNT  = 2'b01;
    localparam bht_cnt_t BHT_WT   = 2'b10;
    localparam bht_cnt_t BHT_ST   = 2'b11;
    localparam bht_cnt_t BHT_INIT = BHT_WNT;

    function automatic logic bht_predicts_taken(input bht_cnt_t cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// 2-bit saturating up/down counter holding one branch history table entry.
// Simultaneous inc and dec leave the count unchanged.
module sat_counter2
    import branch_predict_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     inc,
    input  logic     dec,
    output bht_cnt_t cnt
);

    bht_cnt_t cnt_reg;
    bht_cnt_t cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            if (inc && !dec && cnt_reg != BHT_ST) begin
                cnt_next = cnt_reg + 2'd1;
            end else if (dec && !inc && cnt_reg != BHT_SNT) begin
                cnt_next = cnt_reg - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= BHT_INIT;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/branch_predict_unit.sv
// 2-bit saturating-counter branch predictor: lookup in Decode, prediction
// carried through Execute and Memory, training and statistics in Memory.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcD,
    input  logic             branchD,
    output logic             predict_takenD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             flushM,
    input  logic [31:0]      pcM,
    input  logic             branchM,
    input  logic             takenM,
    output logic             mispredictM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int NUM_ENTRIES = 1 << INDEX_W;

    logic [NUM_ENTRIES-1:0][1:0] bht;
    logic [INDEX_W-1:0]          idx_d;
    logic [INDEX_W-1:0]          idx_m;
    logic                        commit_m;

    logic                        pred_e_reg;
    logic                        pred_m_reg;
    logic [CNT_W-1:0]            branch_cnt_reg;
    logic [CNT_W-1:0]            mispredict_cnt_reg;

    assign idx_d = pcD[INDEX_W+1:2];
    assign idx_m = pcM[INDEX_W+1:2];

    // Word-offset and high PC bits do not take part in indexing (no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcD[31:INDEX_W+2], pcD[1:0], pcM[31:INDEX_W+2], pcM[1:0]};

    // Only a branch that actually leaves Memory this cycle trains the table.
    assign commit_m    = branchM & ~stallM & ~flushM & ~rst;
    assign mispredictM = commit_m & (pred_m_reg != takenM);

    // Reads see the stored value; a same-cycle update is visible next cycle.
    assign predict_takenD = branchD & bht_predicts_taken(bht[idx_d]);

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            sat_counter2 u_cnt (
                .clk (clk),
                .rst (rst),
                .en  (commit_m && (idx_m == INDEX_W'(gi))),
                .inc (takenM),
                .dec (~takenM),
                .cnt (bht[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_e_reg <= 1'b0;
            pred_m_reg <= 1'b0;
        end else begin
            if (flushE) begin
                pred_e_reg <= 1'b0;
            end else if (!stallE) begin
                pred_e_reg <= predict_takenD;
            end
            if (flushM) begin
                pred_m_reg <= 1'b0;
            end else if (!stallM) begin
                pred_m_reg <= pred_e_reg;
            end
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else if (commit_m) begin
            if (branch_cnt_reg != {CNT_W{1'b1}}) begin
                branch_cnt_reg <= branch_cnt_reg + 1'b1;
            end
            if (mispredictM && mispredict_cnt_reg != {CNT_W{1'b1}}) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
            end
        end
    end

    assign branch_cnt     = branch_cnt_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed test of branch_predict_unit: lookup, pipeline, training,
// statistics, flush/stall handling, same-cycle update and mid-run reset.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcD;
    logic        branchD;
    logic        predict_takenD;
    logic        stallE;
    logic        flushE;
    logic        stallM;
    logic        flushM;
    logic [31:0] pcM;
    logic        branchM;
    logic        takenM;
    logic        mispredictM;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] PC4  = 32'h0040_0010;  // index 4
    localparam logic [31:0] PC4A = 32'h0050_0010;  // aliases index 4
    localparam logic [31:0] PC8  = 32'h0040_0020;  // index 8
    localparam logic [31:0] PC9  = 32'h0040_0024;  // index 9

    branch_predict_unit #(.INDEX_W(6), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pcD            (pcD),
        .branchD        (branchD),
        .predict_takenD (predict_takenD),
        .stallE         (stallE),
        .flushE         (flushE),
        .stallM         (stallM),
        .flushM         (flushM),
        .pcM            (pcM),
        .branchM        (branchM),
        .takenM         (takenM),
        .mispredictM    (mispredictM),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs settle by #1 more.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; pcD = 32'h0; branchD = 1'b0;
        stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; flushM = 1'b0;
        pcM = 32'h0; branchM = 1'b0; takenM = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic taken);
        pcM = pc; branchM = 1'b1; takenM = taken;
    endtask

    task automatic lookup(input logic [31:0] pc);
        pcD = pc; branchD = 1'b1;
    endtask

    initial begin
        idle();
        // Reset, with a commit presented that must be ignored.
        rst = 1'b1; commit(PC4, 1'b1);
        #1;
        chk("rst_misp", {31'b0, mispredictM}, 32'd0);
        tick(); tick();
        idle();
        #1;
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispredict_cnt, 32'd0);
        lookup(PC4); #1;
        chk("rst_pred", {31'b0, predict_takenD}, 32'd0);
        tick();

        // Two taken commits: 01 -> 10 -> 11. Pipeline holds 0, so both mispredict.
        idle(); commit(PC4, 1'b1); #1;
        chk("c1_misp", {31'b0, mispredictM}, 32'd1);
        tick();
        idle(); commit(PC4, 1'b1); lookup(PC4); #1;
        chk("c2_pred", {31'b0, predict_takenD}, 32'd1);
        chk("c2_misp", {31'b0, mispredictM}, 32'd1);
        tick();
        // predE=1 now; a non-branch at a taken entry still predicts 0.
        idle(); pcD = PC4; #1;
        chk("c2_bcnt", branch_cnt, 32'd2);
        chk("c2_mcnt", mispredict_cnt, 32'd2);
        chk("nonbr_pred", {31'b0, predict_takenD}, 32'd0);
        tick();

        // predM=1, not-taken, stalled: no mispredict, no commit.
        idle(); commit(PC4, 1'b0); stallM = 1'b1; #1;
        chk("stall_misp", {31'b0, mispredictM}, 32'd0);
        tick();
        idle(); commit(PC4, 1'b0); #1;
        chk("stall_bcnt", branch_cnt, 32'd2);
        chk("unstall_misp", {31'b0, mispredictM}, 32'd1);
        tick();                                   // entry 11 -> 10
        idle(); commit(PC4, 1'b0); lookup(PC4); #1;
        chk("dec1_bcnt", branch_cnt, 32'd3);
        chk("dec1_mcnt", mispredict_cnt, 32'd3);
        chk("dec1_pred", {31'b0, predict_takenD}, 32'd1);
        chk("dec2_misp", {31'b0, mispredictM}, 32'd0);
        tick();                                   // 10 -> 01, predE=1
        idle(); commit(PC4, 1'b0); #1;
        chk("dec3_misp", {31'b0, mispredictM}, 32'd0);
        tick();                                   // 01 -> 00, predM=1
        idle(); commit(PC4, 1'b0); #1;
        chk("dec4_misp", {31'b0, mispredictM}, 32'd1);
        tick();                                   // stays 00
        idle(); lookup(PC4); #1;
        chk("sat0_pred", {31'b0, predict_takenD}, 32'd0);
        chk("sat0_bcnt", branch_cnt, 32'd6);
        chk("sat0_mcnt", mispredict_cnt, 32'd4);
        tick();
        // One taken from 00 gives 01, which must still predict not-taken.
        idle(); commit(PC4, 1'b1); #1;
        tick();
        idle(); lookup(PC4); #1;
        chk("nouflow_pred", {31'b0, predict_takenD}, 32'd0);
        tick();
        idle(); commit(PC4, 1'b1); #1;
        tick();                                   // 01 -> 10, bcnt=8 mcnt=6

        // flushE beats stallE: predE 1 -> 0.
        idle(); lookup(PC4); #1;
        chk("fe_pred", {31'b0, predict_takenD}, 32'd1);
        tick();                                   // predE=1
        idle(); lookup(PC4); flushE = 1'b1; stallE = 1'b1; #1;
        tick();                                   // predE=0, predM=1
        idle(); #1;
        tick();                                   // predM=0
        idle(); commit(PC8, 1'b0); #1;
        chk("fe_misp", {31'b0, mispredictM}, 32'd0);
        tick();                                   // bcnt=9

        // flushM suppresses commit.
        idle(); lookup(PC4); #1;
        tick();                                   // predE=1
        idle(); #1;
        tick();                                   // predM=1
        idle(); commit(PC4, 1'b0); flushM = 1'b1; #1;
        chk("fm_misp", {31'b0, mispredictM}, 32'd0);
        tick();
        idle(); lookup(PC4); #1;
        chk("fm_bcnt", branch_cnt, 32'd9);
        chk("fm_mcnt", mispredict_cnt, 32'd6);
        chk("fm_pred", {31'b0, predict_takenD}, 32'd1);
        tick();                                   // predE=1, predM=0
        idle(); commit(PC4, 1'b0); #1;
        tick();                                   // 10 -> 01, predM=1

        // Same-cycle update and lookup: no bypass.
        idle(); commit(PC4, 1'b1); lookup(PC4); #1;
        chk("byp_same", {31'b0, predict_takenD}, 32'd1 - 32'd1);
        chk("byp_misp", {31'b0, mispredictM}, 32'd0);
        tick();
        idle(); lookup(PC4); #1;
        chk("byp_next", {31'b0, predict_takenD}, 32'd1);
        lookup(PC4A); #1;
        chk("alias_pred", {31'b0, predict_takenD}, 32'd1);
        chk("byp_bcnt", branch_cnt, 32'd11);
        chk("byp_mcnt", mispredict_cnt, 32'd6);
        tick();                                   // predE=1, predM=0

        // A fresh entry starts weak-not-taken: one taken flips it.
        idle(); commit(PC9, 1'b1); #1;
        chk("e9_misp", {31'b0, mispredictM}, 32'd1);
        tick();
        idle(); lookup(PC9); #1;
        chk("e9_pred", {31'b0, predict_takenD}, 32'd1);
        chk("e9_mcnt", mispredict_cnt, 32'd7);
        tick();

        // Mid-run reset with a commit in flight.
        idle(); rst = 1'b1; commit(PC4, 1'b1); #1;
        tick();
        idle(); lookup(PC4); #1;
        chk("mrst_bcnt", branch_cnt, 32'd0);
        chk("mrst_mcnt", mispredict_cnt, 32'd0);
        chk("mrst_pred", {31'b0, predict_takenD}, 32'd0);
        lookup(PC9); #1;
        chk("mrst_pred9", {31'b0, predict_takenD}, 32'd0);
        tick();
        idle(); commit(PC4, 1'b1); #1;
        chk("mrst_misp", {31'b0, mispredictM}, 32'd1);
        tick();
        idle(); lookup(PC4); #1;
        chk("mrst_e4", {31'b0, predict_takenD}, 32'd1);
        chk("mrst_bcnt1", branch_cnt, 32'd1);
        chk("mrst_mcnt1", mispredict_cnt, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- 2-bit saturating-counter branch history table (BHT) for the 5-stage MIPS pipeline.
- Lookup in Decode: supplies a taken/not-taken prediction for each decoded conditional branch (BEQ, BNE, BGEZ, BGEZAL, BLEZ, BLTZ, BLTZAL, BGTZ).
- Carries that prediction down D->E->M alongside the instruction.
- In Memory, consumes the resolved outcome from the branch condition unit, flags a misprediction and trains the table.

Parameters:
- INDEX_W, 6, log2 of BHT entries (64 entries); index = pc[INDEX_W+1:2].
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pcD  in  32  PC of the instruction in Decode.
- branchD  in  1  Decode holds a conditional branch.
- predict_takenD  out  1  prediction for the Decode instruction (combinational).
- stallE  in  1  hold the Execute prediction register.
- flushE  in  1  clear the Execute prediction register.
- stallM  in  1  hold the Memory prediction register; suppress commit.
- flushM  in  1  clear the Memory prediction register; suppress commit.
- pcM  in  32  PC of the branch in Memory.
- branchM  in  1  Memory holds a conditional branch.
- takenM  in  1  resolved outcome (condition unit "ok").
- mispredictM  out  1  prediction differs from the resolved outcome (combinational).
- branch_cnt  out  CNT_W  committed branches.
- mispredict_cnt  out  CNT_W  committed mispredictions.

Behaviour:
- Table:
  - 2^INDEX_W entries of 2 bits; encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - rst: every entry = 01, predE = predM = 0, both stat counters = 0, mispredictM = 0.
- Lookup:
  - predict_takenD = branchD & bht[pcD[INDEX_W+1:2]][1].
  - Asynchronous read, 0 cycles latency.
- Prediction pipeline, priority rst > flush > stall > load:
  - predE <= flushE ? 0 : stallE ? predE : predict_takenD.
  - predM <= flushM ? 0 : stallM ? predM : predE.
  - flushE with stallE set: flush wins.
- Resolution:
  - mispredictM = branchM & ~stallM & ~flushM & (predM != takenM).
- Commit: commitM = branchM & ~stallM & ~flushM. On commitM, the entry at pcM[INDEX_W+1:2] updates on the next clock edge:
  - takenM=1: increment, saturate at 11.
  - takenM=0: decrement, saturate at 00.
  - branch_cnt += 1; mispredict_cnt += mispredictM.
  - Both counters saturate at all-ones and never wrap.
- Read/write same cycle, same index: lookup returns the pre-update value; the new value is visible from the next cycle. There is no bypass.
- Aliasing: PCs sharing index bits share an entry. No tags.
- rst asserted mid-operation: the table and pipeline registers return to reset values at that edge, and in-flight commits are dropped.
- Non-branch in Decode: predict_takenD = 0, so a predicted-taken path is never requested for non-branches.
- Redirect/flush generation on mispredictM is owned by the hazard unit, not this block.

Decomposition:
- Shared defines header additions:
  - BHT_INIT (2'b01).
  - Counter encodings: BHT_SNT, BHT_WNT, BHT_WT, BHT_ST.
- Sub-module sat_counter2: 2-bit saturating up/down counter with inc/dec/en. Instantiated per entry or used as next-state function.
- Everything else lives in branch_predict_unit.

Test Plan:
- Reset, then pcD=0x00400010, branchD=1 -> predict_takenD=0; all entries read 01.
- Commit taken twice at pcM=0x00400010 (branchM=1, takenM=1) -> entry 4 goes 01->10->11; next lookup of 0x00400010 -> predict_takenD=1; branch_cnt=2.
- Entry at 11; commit not-taken once -> 10, still predicts taken. Three more not-taken -> 00; further not-taken stays 00 (no underflow).
- predE=1 pipelined to M, takenM=0, branchM=1 -> mispredictM=1, mispredict_cnt increments by 1. Same cycle with stallM=1 -> mispredictM=0, no table or counter change until stall drops.
- flushE=1 and stallE=1 together while predict_takenD=1 -> predE=0 next cycle. flushM with branchM=1 -> no commit.
- Commit to index 4 in the same cycle pcD maps to index 4 (entry 01, takenM=1) -> predict_takenD=0 that cycle, 1 the next cycle. Assert rst mid-sequence -> entry back to 01, counters 0.
